// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/return sequencer feeding the CSR file trap-update port and owning the privilege level.
// Latency: trap accept -> trap_taken +1 -> redirect/trap_done +2, next accept at +3; MRET accept -> mret/redirect +1.
// Backpressure: requests are level-held until acked; nothing is acked outside IDLE, and stall/flush hold the pipeline meanwhile.
module csr_trap_ctrl #(
    parameter int         XLEN       = 64,
    parameter logic [1:0] RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] cur_pc,
    input  logic            exc_req,
    input  logic [3:0]      exc_code_in,
    input  logic [XLEN-1:0] exc_val_in,
    input  logic            mret_req,
    input  logic            irq_req,
    input  logic [3:0]      irq_code,
    input  logic [XLEN-1:0] mstatus_current,
    input  logic [XLEN-1:0] mtvec_trap,
    input  logic [XLEN-1:0] mepc_out,
    output logic            exc_ack,
    output logic            mret_ack,
    output logic            irq_ack,
    output logic            stall,
    output logic            flush,
    output logic            trap_taken,
    output logic            trap_done,
    output logic            mret,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic [XLEN-1:0] mstatus_next,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      priv_lvl
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_TRAP_SAVE = 2'd1,
        S_TRAP_VEC  = 2'd2,
        S_RET       = 2'd3
    } state_t;

    state_t          r_state;
    logic [1:0]      r_priv;
    logic [1:0]      r_ret_priv;
    logic            r_is_irq;
    logic [3:0]      r_code;

    logic            w_idle;
    logic            w_irq_ok;
    logic            w_take_exc;
    logic            w_take_mret;
    logic            w_take_irq;
    logic            w_accept;
    logic [XLEN-1:0] w_ms_trap;
    logic [XLEN-1:0] w_ms_ret;
    logic [1:0]      w_mpp_priv;
    logic [XLEN-1:0] w_vec_base;
    logic [XLEN-1:0] w_vec_off;
    logic [XLEN-1:0] w_trap_pc;

    // Acks are decoded combinationally so the accept cycle is the cycle the request is seen in IDLE;
    // gating with rst keeps acks, stall and flush low while reset is asserted.
    assign w_idle      = rst && (r_state == S_IDLE);
    assign w_irq_ok    = irq_req && ((r_priv != 2'b11) || mstatus_current[3]);
    assign w_take_exc  = w_idle && exc_req;
    assign w_take_mret = w_idle && !exc_req && mret_req;
    assign w_take_irq  = w_idle && !exc_req && !mret_req && w_irq_ok;
    assign w_accept    = w_take_exc || w_take_mret || w_take_irq;

    assign exc_ack  = w_take_exc;
    assign mret_ack = w_take_mret;
    assign irq_ack  = w_take_irq;
    assign stall    = w_accept || (rst && (r_state != S_IDLE));
    assign flush    = stall;
    assign priv_lvl = r_priv;

    // Trap entry stacks MIE into MPIE, disables MIE and records the privilege being left in MPP.
    always_comb begin
        w_ms_trap        = mstatus_current;
        w_ms_trap[7]     = mstatus_current[3];
        w_ms_trap[3]     = 1'b0;
        w_ms_trap[12:11] = r_priv;
    end

    // MRET restores MIE from MPIE, re-arms MPIE and drops MPP to U; reserved MPP=10 resolves to U.
    always_comb begin
        w_ms_ret        = mstatus_current;
        w_ms_ret[3]     = mstatus_current[7];
        w_ms_ret[7]     = 1'b1;
        w_ms_ret[12:11] = 2'b00;
        w_mpp_priv      = mstatus_current[12:11];
        if (mstatus_current[12:11] == 2'b10) begin
            w_mpp_priv = 2'b00;
        end
    end

    // Vectored mode only applies to interrupts; exceptions always land on the aligned base.
    assign w_vec_base = {mtvec_trap[XLEN-1:2], 2'b00};
    assign w_vec_off  = {{(XLEN-6){1'b0}}, r_code, 2'b00};
    assign w_trap_pc  = (r_is_irq && (mtvec_trap[1:0] == 2'b01)) ? (w_vec_base + w_vec_off) : w_vec_base;

    // Sequencer: strobes are single-cycle registered pulses; CSR values latched on accept hold until the next accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_priv         <= RESET_PRIV;
            r_ret_priv     <= 2'b00;
            r_is_irq       <= 1'b0;
            r_code         <= 4'd0;
            trap_taken     <= 1'b0;
            trap_done      <= 1'b0;
            mret           <= 1'b0;
            redirect_valid <= 1'b0;
            mepc_next      <= '0;
            mcause_next    <= '0;
            mtval_next     <= '0;
            mstatus_next   <= '0;
            redirect_pc    <= '0;
        end else begin
            trap_taken     <= 1'b0;
            trap_done      <= 1'b0;
            mret           <= 1'b0;
            redirect_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take_exc) begin
                        mepc_next    <= {cur_pc[XLEN-1:2], 2'b00};
                        mcause_next  <= {1'b0, {(XLEN-5){1'b0}}, exc_code_in};
                        mtval_next   <= exc_val_in;
                        mstatus_next <= w_ms_trap;
                        r_is_irq     <= 1'b0;
                        r_code       <= exc_code_in;
                        trap_taken   <= 1'b1;
                        r_state      <= S_TRAP_SAVE;
                    end else if (w_take_mret) begin
                        mstatus_next   <= w_ms_ret;
                        r_ret_priv     <= w_mpp_priv;
                        mret           <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mepc_out;
                        r_state        <= S_RET;
                    end else if (w_take_irq) begin
                        mepc_next    <= cur_pc;
                        mcause_next  <= {1'b1, {(XLEN-5){1'b0}}, irq_code};
                        mtval_next   <= '0;
                        mstatus_next <= w_ms_trap;
                        r_is_irq     <= 1'b1;
                        r_code       <= irq_code;
                        trap_taken   <= 1'b1;
                        r_state      <= S_TRAP_SAVE;
                    end
                end
                S_TRAP_SAVE: begin
                    redirect_valid <= 1'b1;
                    trap_done      <= 1'b1;
                    redirect_pc    <= w_trap_pc;
                    r_state        <= S_TRAP_VEC;
                end
                S_TRAP_VEC: begin
                    r_priv  <= 2'b11;
                    r_state <= S_IDLE;
                end
                S_RET: begin
                    r_priv  <= r_ret_priv;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
